// File: rtl/op_sched_pkg.sv
// Shared types and helpers for the operation scheduler: FSM encoding and
// watchdog counter sizing.
package op_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Bits needed to count 0..tmo-1; never less than one bit.
    function automatic int wd_width(input int tmo);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < tmo) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/operation_sched_rr_arbiter.sv
// Rotating-priority pick: the first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [PW-1:0]   win_idx,
    output logic            any
);

    int          j;
    logic [PW-1:0] idx;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        j       = 0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            idx = PW'(j);
            if (!any && req[idx]) begin
                any         = 1'b1;
                win_idx     = idx;
                win_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/operation_sched.sv
// Shares one start/ready operation core between NREQ requesters: round-robin
// grant, core clear, start/ready sequencing, result capture and watchdog abort.
//
// state | meaning
// IDLE  | waiting for a request; picks winner and latches its operands
// CLR   | core held in reset for one cycle, watchdog cleared
// RUN   | start held high until core ready or watchdog limit
// FIN   | DONE or ERR pulse to winner; pointer moves past winner
module operation_sched
    import op_sched_pkg::*;
#(
    parameter int BW   = 16,
    parameter int INC  = 3,
    parameter int NREQ = 4,
    parameter int TMO  = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*INC*BW-1:0] ARGS,
    output logic [NREQ-1:0]       GNT,
    output logic [NREQ-1:0]       DONE,
    output logic [NREQ-1:0]       ERR,
    output logic [BW-1:0]         RES,
    output logic                  OP_RST,
    output logic                  OP_ST,
    output logic [INC*BW-1:0]     OP_IN,
    input  logic                  OP_RD,
    input  logic [BW-1:0]         OP_RES
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = wd_width(TMO);

    state_t              state;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       win_q;
    logic [WW-1:0]       wdog;
    logic [NREQ-1:0]     pick_oh;
    logic [PW-1:0]       pick_idx;
    logic                pick_any;
    logic [INC*BW-1:0]   arg_sel;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req     (REQ),
        .ptr     (ptr),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        arg_sel = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (pick_idx == PW'(r)) arg_sel = ARGS[r*INC*BW +: INC*BW];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            GNT    <= '0;
            DONE   <= '0;
            ERR    <= '0;
            RES    <= '0;
            OP_RST <= 1'b1;
            OP_ST  <= 1'b0;
            OP_IN  <= '0;
            ptr    <= '0;
            win_q  <= '0;
            wdog   <= '0;
        end else begin
            DONE <= '0;
            ERR  <= '0;
            case (state)
                IDLE: begin
                    OP_RST <= 1'b0;
                    OP_ST  <= 1'b0;
                    if (pick_any) begin
                        GNT    <= pick_oh;
                        win_q  <= pick_idx;
                        OP_IN  <= arg_sel;
                        OP_RST <= 1'b1;
                        state  <= CLR;
                    end
                end
                CLR: begin
                    OP_RST <= 1'b0;
                    OP_ST  <= 1'b1;
                    wdog   <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    // Ready takes priority over the watchdog in the same cycle.
                    if (OP_RD) begin
                        RES   <= OP_RES;
                        DONE  <= GNT;
                        OP_ST <= 1'b0;
                        state <= FIN;
                    end else if (wdog == WW'(TMO - 1)) begin
                        ERR   <= GNT;
                        OP_ST <= 1'b0;
                        state <= FIN;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                FIN: begin
                    GNT   <= '0;
                    ptr   <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_operation_sched.sv
// Directed bench for operation_sched with an adder core model whose ready
// latency is programmable.
module tb_operation_sched;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [3:0]   REQ = '0;
    logic [191:0] ARGS = '0;
    logic [3:0]   GNT, DONE, ERR;
    logic [15:0]  RES;
    logic         OP_RST, OP_ST, OP_RD;
    logic [47:0]  OP_IN;
    logic [15:0]  OP_RES;

    int checks = 0;
    int failures = 0;
    int d_cfg = 1000;
    int st_cnt = 0;

    operation_sched #(.BW(16), .INC(3), .NREQ(4), .TMO(8)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .ARGS(ARGS),
        .GNT(GNT), .DONE(DONE), .ERR(ERR), .RES(RES),
        .OP_RST(OP_RST), .OP_ST(OP_ST), .OP_IN(OP_IN),
        .OP_RD(OP_RD), .OP_RES(OP_RES)
    );

    always #5 CLK = ~CLK;

    // Core model: sum of operands, ready once ST has been high for d_cfg cycles.
    always @(posedge CLK) begin
        if (OP_RST) st_cnt <= 0;
        else if (OP_ST) st_cnt <= st_cnt + 1;
    end
    assign OP_RD  = OP_ST && (st_cnt >= d_cfg);
    assign OP_RES = OP_IN[15:0] + OP_IN[31:16] + OP_IN[47:32];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic set_args(input int r, input logic [15:0] a0, input logic [15:0] a1,
                            input logic [15:0] a2);
        ARGS[(r*3+0)*16 +: 16] = a0;
        ARGS[(r*3+1)*16 +: 16] = a1;
        ARGS[(r*3+2)*16 +: 16] = a2;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    // Follows one operation up to its DONE/ERR cycle; returns what it saw.
    task automatic observe_op(output logic [3:0] g, output logic [3:0] dn,
                              output logic [3:0] er, output logic [15:0] rs,
                              output int st_cyc, output int rst_cyc,
                              output int idle_cyc, output bit tmo);
        g = '0; dn = '0; er = '0; rs = '0;
        st_cyc = 0; rst_cyc = 0; idle_cyc = 0; tmo = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (GNT == 4'b0000) begin
                idle_cyc++;
            end else begin
                g = GNT;
                if (OP_RST) rst_cyc++;
                if (OP_ST) st_cyc++;
                if ((DONE | ERR) != 4'b0000) begin
                    dn = DONE; er = ERR; rs = RES; tmo = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; REQ = '0;
        tick(); tick();
        checks++; if (GNT !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b want 0000", GNT); end
        checks++; if (DONE !== 4'b0000) begin failures++; $display("FAIL reset_done: got %b want 0000", DONE); end
        checks++; if (ERR !== 4'b0000) begin failures++; $display("FAIL reset_err: got %b want 0000", ERR); end
        checks++; if (RES !== 16'h0000) begin failures++; $display("FAIL reset_res: got %h want 0000", RES); end
        checks++; if (OP_ST !== 1'b0) begin failures++; $display("FAIL reset_op_st: got %b want 0", OP_ST); end
        checks++; if (OP_RST !== 1'b1) begin failures++; $display("FAIL reset_op_rst: got %b want 1", OP_RST); end
        checks++; if (OP_IN !== 48'h0) begin failures++; $display("FAIL reset_op_in: got %h want 0", OP_IN); end
    endtask

    task automatic test_single();
        logic [3:0] g, dn, er; logic [15:0] rs; int st, rc, id; bit tmo;
        set_args(0, 16'd0, 16'd1, 16'd2);
        d_cfg = 3;
        RST = 1'b0; REQ = 4'b0001;
        observe_op(g, dn, er, rs, st, rc, id, tmo);
        REQ = 4'b0000;
        checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL single_timeout: got %b want 0", tmo); end
        checks++; if (g !== 4'b0001) begin failures++; $display("FAIL single_gnt: got %b want 0001", g); end
        checks++; if (id !== 0) begin failures++; $display("FAIL single_latency: got %0d idle want 0", id); end
        checks++; if (rc !== 1) begin failures++; $display("FAIL single_op_rst_cycles: got %0d want 1", rc); end
        checks++; if (st !== 4) begin failures++; $display("FAIL single_op_st_cycles: got %0d want 4", st); end
        checks++; if (dn !== 4'b0001) begin failures++; $display("FAIL single_done: got %b want 0001", dn); end
        checks++; if (er !== 4'b0000) begin failures++; $display("FAIL single_err: got %b want 0000", er); end
        checks++; if (rs !== 16'd3) begin failures++; $display("FAIL single_res: got %h want 0003", rs); end
        checks++; if (OP_IN !== 48'h0002_0001_0000) begin failures++; $display("FAIL single_op_in: got %h want 000200010000", OP_IN); end
        tick();
        checks++; if ((DONE | ERR | GNT) !== 4'b0000) begin failures++; $display("FAIL single_pulse_end: got done=%b err=%b gnt=%b want 0", DONE, ERR, GNT); end
    endtask

    task automatic test_round_robin();
        logic [3:0] g, dn, er; logic [15:0] rs; int st, rc, id; bit tmo;
        int exp_idx [5] = '{0, 1, 2, 3, 0};
        logic [15:0] exp_sum [5] = '{16'd3, 16'd60, 16'd600, 16'd1002, 16'd3};
        do_reset();
        set_args(1, 16'd10, 16'd20, 16'd30);
        set_args(2, 16'd100, 16'd200, 16'd300);
        set_args(3, 16'd1000, 16'd1, 16'd1);
        d_cfg = 1;
        REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            observe_op(g, dn, er, rs, st, rc, id, tmo);
            checks++; if (tmo !== 1'b0 || g !== (4'b0001 << exp_idx[k])) begin failures++; $display("FAIL rr_gnt[%0d]: got %b want bit %0d", k, g, exp_idx[k]); end
            checks++; if (dn !== g || er !== 4'b0000) begin failures++; $display("FAIL rr_done[%0d]: got done=%b err=%b want done=%b", k, dn, er, g); end
            checks++; if (rs !== exp_sum[k]) begin failures++; $display("FAIL rr_res[%0d]: got %h want %h", k, rs, exp_sum[k]); end
            checks++; if (st !== 2) begin failures++; $display("FAIL rr_op_st_cycles[%0d]: got %0d want 2", k, st); end
            checks++; if (id !== ((k == 0) ? 0 : 1)) begin failures++; $display("FAIL rr_idle_gap[%0d]: got %0d want %0d", k, id, (k == 0) ? 0 : 1); end
        end
        REQ = 4'b0000;
        tick();
        checks++; if ((DONE | GNT) !== 4'b0000) begin failures++; $display("FAIL rr_end: got done=%b gnt=%b want 0", DONE, GNT); end
    endtask

    task automatic test_overflow();
        logic [3:0] g, dn, er; logic [15:0] rs; int st, rc, id; bit tmo;
        set_args(2, 16'hFFFF, 16'h0001, 16'h0002);
        d_cfg = 2;
        REQ = 4'b0100;
        observe_op(g, dn, er, rs, st, rc, id, tmo);
        REQ = 4'b0000;
        checks++; if (tmo !== 1'b0 || g !== 4'b0100) begin failures++; $display("FAIL ovf_gnt: got %b want 0100", g); end
        checks++; if (dn !== 4'b0100 || er !== 4'b0000) begin failures++; $display("FAIL ovf_done: got done=%b err=%b want 0100/0000", dn, er); end
        checks++; if (rs !== 16'h0002) begin failures++; $display("FAIL ovf_res: got %h want 0002", rs); end
        checks++; if (st !== 3) begin failures++; $display("FAIL ovf_op_st_cycles: got %0d want 3", st); end
        tick();
    endtask

    task automatic test_timeout();
        logic [3:0] g, dn, er; logic [15:0] rs; int st, rc, id; bit tmo;
        d_cfg = 1000;
        REQ = 4'b0001;
        observe_op(g, dn, er, rs, st, rc, id, tmo);
        REQ = 4'b0000;
        checks++; if (tmo !== 1'b0 || g !== 4'b0001) begin failures++; $display("FAIL tmo_gnt: got %b want 0001", g); end
        checks++; if (er !== 4'b0001 || dn !== 4'b0000) begin failures++; $display("FAIL tmo_err: got err=%b done=%b want 0001/0000", er, dn); end
        checks++; if (st !== 8) begin failures++; $display("FAIL tmo_op_st_cycles: got %0d want 8", st); end
        checks++; if (rs !== 16'h0002) begin failures++; $display("FAIL tmo_res_kept: got %h want 0002", rs); end
        tick();
        checks++; if (ERR !== 4'b0000) begin failures++; $display("FAIL tmo_err_pulse: got %b want 0000", ERR); end
        // Ready arriving on the last watchdog cycle must still complete normally.
        d_cfg = 7;
        REQ = 4'b0011;
        observe_op(g, dn, er, rs, st, rc, id, tmo);
        REQ = 4'b0000;
        checks++; if (tmo !== 1'b0 || g !== 4'b0010) begin failures++; $display("FAIL tmo_ptr_adv: got %b want 0010", g); end
        checks++; if (dn !== 4'b0010 || er !== 4'b0000) begin failures++; $display("FAIL tmo_edge_done: got done=%b err=%b want 0010/0000", dn, er); end
        checks++; if (st !== 8) begin failures++; $display("FAIL tmo_edge_st_cycles: got %0d want 8", st); end
        checks++; if (rs !== 16'd60) begin failures++; $display("FAIL tmo_edge_res: got %h want 003c", rs); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] g, dn, er; logic [15:0] rs; int st, rc, id; bit tmo; bit seen;
        d_cfg = 1000;
        REQ = 4'b0100;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (OP_ST) begin seen = 1'b1; break; end
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL midrst_run_reached: got %b want 1", seen); end
        tick(); tick();
        RST = 1'b1;
        tick();
        checks++; if (GNT !== 4'b0000 || OP_ST !== 1'b0) begin failures++; $display("FAIL midrst_idle: got gnt=%b st=%b want 0/0", GNT, OP_ST); end
        checks++; if (OP_RST !== 1'b1) begin failures++; $display("FAIL midrst_op_rst: got %b want 1", OP_RST); end
        checks++; if ((DONE | ERR) !== 4'b0000) begin failures++; $display("FAIL midrst_silent: got done=%b err=%b want 0", DONE, ERR); end
        checks++; if (RES !== 16'h0000) begin failures++; $display("FAIL midrst_res: got %h want 0000", RES); end
        RST = 1'b0;
        d_cfg = 1;
        REQ = 4'b0110;
        observe_op(g, dn, er, rs, st, rc, id, tmo);
        REQ = 4'b0000;
        checks++; if (tmo !== 1'b0 || g !== 4'b0010) begin failures++; $display("FAIL midrst_first_gnt: got %b want 0010", g); end
        checks++; if (dn !== 4'b0010 || er !== 4'b0000) begin failures++; $display("FAIL midrst_done: got done=%b err=%b want 0010/0000", dn, er); end
        checks++; if (rs !== 16'd60) begin failures++; $display("FAIL midrst_res_after: got %h want 003c", rs); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_timeout();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
